// File: rtl/fifo_ctrl_thr_pkg.sv
// Shared definitions for the threshold FIFO: FSM state encodings and the
// depth/pointer-width consistency check used at elaboration.
package fifo_ctrl_thr_pkg;

   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_INIT   = 3'd1,
      ST_IDLE   = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_ERROR  = 3'd4
   } state_t;

   // Pointers wrap naturally, so the depth must be an exact power of two.
   function automatic bit depth_ok(input int aw, input int depth);
      return depth == (1 << aw);
   endfunction

endpackage

// File: rtl/fifo_ctrl_thr_memory_dp.sv
// Dual-port FIFO storage: one write port, one registered read port with enable.
// The array itself is never reset; only the read register is.
module memory_dp #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 3,
   parameter int BUFFER_DEPTH  = 8
) (
   input  logic                     CLK,
   input  logic                     RESET_L,
   input  logic                     i_wr_en,
   input  logic [ADDRESS_WIDTH-1:0] i_wr_addr,
   input  logic [DATA_WIDTH-1:0]    i_wr_data,
   input  logic                     i_rd_en,
   input  logic [ADDRESS_WIDTH-1:0] i_rd_addr,
   output logic [DATA_WIDTH-1:0]    o_rd_data
);

   logic [DATA_WIDTH-1:0] r_mem [BUFFER_DEPTH];
   logic [DATA_WIDTH-1:0] r_rd_data;

   always_ff @(posedge CLK) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   end

   // Read-before-write on a shared address, so push+pop at full returns the old word.
   always_ff @(posedge CLK) begin
      if (!RESET_L)     r_rd_data <= '0;
      else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fifo_ctrl_thr.sv
// Synchronous FIFO with latched almost-full/almost-empty thresholds and an
// overflow/underflow FSM. Optional macro FIFO_ERR_RECOVER_EN makes ERROR a 1-cycle pulse.
//
// state  | meaning
// RESET  | held in reset, waiting for RESET_L release
// INIT   | latch TH_FULL/TH_EMPTY, no push/pop
// IDLE   | running, COUNT == 0
// ACTIVE | running, COUNT > 0
// ERROR  | overflow/underflow seen, push/pop blocked
module fifo_ctrl_thr
   import fifo_ctrl_thr_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 3,
   parameter int BUFFER_DEPTH  = 8
) (
   input  logic                     CLK,
   input  logic                     RESET_L,
   input  logic                     ENB,
   input  logic                     sWrite,
   input  logic                     sRead,
   input  logic [DATA_WIDTH-1:0]    inputData,
   input  logic [ADDRESS_WIDTH:0]   TH_FULL,
   input  logic [ADDRESS_WIDTH:0]   TH_EMPTY,
   output logic [DATA_WIDTH-1:0]    outputData,
   output logic                     VALID_OUT,
   output logic                     FULL,
   output logic                     EMPTY,
   output logic                     ALMOST_FULL,
   output logic                     ALMOST_EMPTY,
   output logic                     ERROR,
   output logic [ADDRESS_WIDTH:0]   COUNT,
   output logic [2:0]               STATE
);

   localparam int CW = ADDRESS_WIDTH + 1;

   if (!depth_ok(ADDRESS_WIDTH, BUFFER_DEPTH)) begin : g_depth_chk
      $error("fifo_ctrl_thr: BUFFER_DEPTH must equal 2**ADDRESS_WIDTH");
   end

   state_t                   r_state, w_state_n;
   logic [ADDRESS_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]            r_count, w_count_n;
   logic [CW-1:0]            r_th_full, r_th_empty, w_th_full_n, w_th_empty_n;
   logic                     r_full, r_empty, r_afull, r_aempty, r_error, r_valid;
   logic                     w_run, w_push, w_pop, w_ovf, w_unf, w_error_n;

   always_comb begin
      w_run        = ENB && (r_state == ST_IDLE || r_state == ST_ACTIVE);
      w_pop        = w_run && sRead && !r_empty;
      w_push       = w_run && sWrite && (!r_full || w_pop);
      w_ovf        = w_run && sWrite && r_full && !w_pop;
      w_unf        = w_run && sRead && r_empty;
      w_count_n    = r_count + CW'(w_push) - CW'(w_pop);
      w_th_full_n  = (r_state == ST_INIT) ? TH_FULL  : r_th_full;
      w_th_empty_n = (r_state == ST_INIT) ? TH_EMPTY : r_th_empty;
   end

   always_comb begin
      w_state_n = r_state;
      w_error_n = r_error;
      case (r_state)
         ST_RESET: w_state_n = ST_INIT;
         ST_INIT:  w_state_n = ST_IDLE;
         ST_IDLE, ST_ACTIVE: begin
            if (w_ovf || w_unf) begin
               w_state_n = ST_ERROR;
               w_error_n = 1'b1;
            end else begin
               w_state_n = (w_count_n == '0) ? ST_IDLE : ST_ACTIVE;
            end
         end
         ST_ERROR: begin
`ifdef FIFO_ERR_RECOVER_EN
            w_state_n = (r_count == '0) ? ST_IDLE : ST_ACTIVE;
            w_error_n = 1'b0;
`else
            w_state_n = ST_ERROR;
`endif
         end
         default:  w_state_n = ST_RESET;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET_L) begin
         r_state    <= ST_RESET;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_th_full  <= '0;
         r_th_empty <= '0;
         r_full     <= 1'b0;
         r_empty    <= 1'b1;
         r_afull    <= 1'b0;
         r_aempty   <= 1'b1;
         r_error    <= 1'b0;
         r_valid    <= 1'b0;
      end else if (ENB) begin
         r_state    <= w_state_n;
         r_error    <= w_error_n;
         r_valid    <= w_pop;
         r_count    <= w_count_n;
         r_th_full  <= w_th_full_n;
         r_th_empty <= w_th_empty_n;
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         // Flags keep their reset values until thresholds are latched in INIT.
         if (r_state != ST_RESET) begin
            r_full   <= (w_count_n == CW'(BUFFER_DEPTH));
            r_empty  <= (w_count_n == '0);
            r_afull  <= (w_count_n >= w_th_full_n);
            r_aempty <= (w_count_n <= w_th_empty_n);
         end
      end else begin
         r_valid <= 1'b0;
      end
   end

   memory_dp #(
      .DATA_WIDTH    (DATA_WIDTH),
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .BUFFER_DEPTH  (BUFFER_DEPTH)
   ) u_mem (
      .CLK       (CLK),
      .RESET_L   (RESET_L),
      .i_wr_en   (w_push),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (inputData),
      .i_rd_en   (w_pop),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (outputData)
   );

   assign VALID_OUT    = r_valid;
   assign FULL         = r_full;
   assign EMPTY        = r_empty;
   assign ALMOST_FULL  = r_afull;
   assign ALMOST_EMPTY = r_aempty;
   assign ERROR        = r_error;
   assign COUNT        = r_count;
   assign STATE        = r_state;

endmodule

// File: tb/tb_fifo_ctrl_thr.sv
// Directed self-checking bench for fifo_ctrl_thr (DATA_WIDTH=8, ADDRESS_WIDTH=3).
// Expectations for the ERROR segments follow FIFO_ERR_RECOVER_EN when it is defined.
module tb_fifo_ctrl_thr;

   logic       CLK = 1'b0;
   logic       RESET_L, ENB, sWrite, sRead;
   logic [7:0] inputData;
   logic [3:0] TH_FULL, TH_EMPTY;
   logic [7:0] outputData;
   logic       VALID_OUT, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, ERROR;
   logic [3:0] COUNT;
   logic [2:0] STATE;

   int n_vec = 0;
   int n_err = 0;

   fifo_ctrl_thr #(.DATA_WIDTH(8), .ADDRESS_WIDTH(3), .BUFFER_DEPTH(8)) dut (
      .CLK          (CLK),
      .RESET_L      (RESET_L),
      .ENB          (ENB),
      .sWrite       (sWrite),
      .sRead        (sRead),
      .inputData    (inputData),
      .TH_FULL      (TH_FULL),
      .TH_EMPTY     (TH_EMPTY),
      .outputData   (outputData),
      .VALID_OUT    (VALID_OUT),
      .FULL         (FULL),
      .EMPTY        (EMPTY),
      .ALMOST_FULL  (ALMOST_FULL),
      .ALMOST_EMPTY (ALMOST_EMPTY),
      .ERROR        (ERROR),
      .COUNT        (COUNT),
      .STATE        (STATE)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, clock once, sample 1 time unit after the edge.
   task automatic step(input logic wr, input logic rd, input logic [7:0] d, input logic en);
      sWrite    = wr;
      sRead     = rd;
      inputData = d;
      ENB       = en;
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset_init();
      RESET_L = 1'b0;
      step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 1);
      RESET_L = 1'b1;
      step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 1);
   endtask

   logic [7:0] exp_pop [8];

   initial begin
      RESET_L = 1'b0; ENB = 1'b1; sWrite = 1'b0; sRead = 1'b0;
      inputData = 8'h00; TH_FULL = 4'd6; TH_EMPTY = 4'd1;
      step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 1);
      chk("rst_state", STATE, 0);
      chk("rst_count", COUNT, 0);
      chk("rst_flags", {FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, ERROR, VALID_OUT}, 6'b010100);
      chk("rst_data", outputData, 8'h00);

      RESET_L = 1'b1;
      step(0, 0, 8'h00, 1);
      chk("init_state", STATE, 1);
      chk("init_flags", {EMPTY, ALMOST_FULL, ALMOST_EMPTY}, 3'b101);
      step(0, 0, 8'h00, 1);
      chk("idle_state", STATE, 2);
      chk("idle_flags", {FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY}, 4'b0101);
      chk("idle_count", COUNT, 0);

      // Fill: 1,2,4,...,32 then 64,128
      for (int i = 0; i < 8; i++) begin
         step(1, 0, 8'(1 << i), 1);
         chk("fill_count", COUNT, i + 1);
         chk("fill_aempty", ALMOST_EMPTY, (i + 1 <= 1));
         chk("fill_afull", ALMOST_FULL, (i + 1 >= 6));
         chk("fill_full", FULL, (i == 7));
      end
      chk("full_state", STATE, 3);

      step(1, 1, 8'hAA, 1);
      chk("pp_data", outputData, 8'h01);
      chk("pp_valid", VALID_OUT, 1);
      chk("pp_count", COUNT, 8);
      chk("pp_flags", {FULL, ERROR}, 2'b10);

      exp_pop = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'hAA};
      for (int i = 0; i < 8; i++) begin
         step(0, 1, 8'h00, 1);
         chk("drain_data", outputData, exp_pop[i]);
         chk("drain_valid", VALID_OUT, 1);
         chk("drain_count", COUNT, 7 - i);
      end
      chk("drain_flags", {FULL, EMPTY, ALMOST_EMPTY, ERROR}, 4'b0110);
      chk("drain_state", STATE, 2);
      step(0, 0, 8'h00, 1);
      chk("hold_valid", VALID_OUT, 0);
      chk("hold_data", outputData, 8'hAA);

      // Enable low: nothing moves, VALID_OUT stays low
      step(1, 0, 8'h11, 1);
      chk("pre_enb_count", COUNT, 1);
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 8'h99, 0);
         chk("enb0_count", COUNT, 1);
         chk("enb0_valid", VALID_OUT, 0);
         chk("enb0_state", STATE, 3);
         chk("enb0_data", outputData, 8'hAA);
      end
      step(0, 1, 8'h00, 1);
      chk("post_enb_data", outputData, 8'h11);
      chk("post_enb_count", COUNT, 0);

      // Underflow
      step(0, 1, 8'h00, 1);
      chk("unf_error", ERROR, 1);
      chk("unf_state", STATE, 4);
      chk("unf_valid", VALID_OUT, 0);
      chk("unf_data", outputData, 8'h11);
      chk("unf_count", COUNT, 0);
      step(1, 0, 8'h22, 1);
`ifdef FIFO_ERR_RECOVER_EN
      chk("unf_rec_error", ERROR, 0);
      chk("unf_rec_state", STATE, 2);
`else
      chk("unf_stk_error", ERROR, 1);
      chk("unf_stk_state", STATE, 4);
      chk("unf_stk_count", COUNT, 0);
`endif

      // Reset mid-operation, then overflow; thresholds must stay latched at 6/1
      do_reset_init();
      chk("rst2_state", STATE, 2);
      chk("rst2_flags", {EMPTY, ERROR, ALMOST_EMPTY}, 3'b101);
      chk("rst2_count", COUNT, 0);
      TH_FULL = 4'd2;
      for (int i = 0; i < 8; i++) begin
         step(1, 0, 8'(8'h30 + i), 1);
         chk("fill2_afull", ALMOST_FULL, (i + 1 >= 6));
      end
      chk("fill2_full", FULL, 1);
      step(1, 0, 8'hEE, 1);
      chk("ovf_error", ERROR, 1);
      chk("ovf_state", STATE, 4);
      chk("ovf_count", COUNT, 8);
      step(0, 0, 8'h00, 1);
`ifdef FIFO_ERR_RECOVER_EN
      chk("ovf_rec_error", ERROR, 0);
      chk("ovf_rec_state", STATE, 3);
      step(0, 1, 8'h00, 1);
      chk("ovf_rec_data", outputData, 8'h30);
      chk("ovf_rec_count", COUNT, 7);
`else
      chk("ovf_stk_error", ERROR, 1);
      chk("ovf_stk_state", STATE, 4);
      step(0, 1, 8'h00, 1);
      chk("ovf_stk_valid", VALID_OUT, 0);
      chk("ovf_stk_count", COUNT, 8);
`endif

      // Reset discards stored data; pointers restart at 0
      TH_FULL = 4'd6;
      do_reset_init();
      chk("rst3_count", COUNT, 0);
      step(1, 0, 8'h77, 1);
      step(0, 1, 8'h00, 1);
      chk("rst3_data", outputData, 8'h77);
      chk("rst3_flags", {EMPTY, VALID_OUT, ERROR}, 3'b110);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_ctrl_thr.md
Name: fifo_ctrl_thr

Overview:
- Parametrised synchronous FIFO: dual-port storage, read/write pointer control, occupancy count.
- Programmable almost-full/almost-empty thresholds, latched at init.
- Overflow/underflow detection through a small control FSM.
- Sits between a producer and a consumer in the project datapath; supersedes direct address-driven memory access, so callers issue push/pop only.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDRESS_WIDTH, 3, pointer width.
- BUFFER_DEPTH, 8, number of entries; must equal 2**ADDRESS_WIDTH.

Ports:
- CLK  in  1  clock, rising edge.
- RESET_L  in  1  synchronous, active-low reset.
- ENB  in  1  global enable; low = hold all state and outputs.
- sWrite  in  1  push request.
- sRead  in  1  pop request.
- inputData  in  DATA_WIDTH  push data.
- TH_FULL  in  ADDRESS_WIDTH+1  almost-full threshold, sampled in INIT.
- TH_EMPTY  in  ADDRESS_WIDTH+1  almost-empty threshold, sampled in INIT.
- outputData  out  DATA_WIDTH  popped word, registered.
- VALID_OUT  out  1  outputData valid this cycle.
- FULL  out  1  COUNT == BUFFER_DEPTH.
- EMPTY  out  1  COUNT == 0.
- ALMOST_FULL  out  1  COUNT >= latched TH_FULL.
- ALMOST_EMPTY  out  1  COUNT <= latched TH_EMPTY.
- ERROR  out  1  overflow/underflow occurred.
- COUNT  out  ADDRESS_WIDTH+1  occupancy.
- STATE  out  3  FSM state, for debug.

Behaviour:
- Reset: sampled on CLK rising edge while RESET_L=0. Outputs go to outputData=0, VALID_OUT=0, FULL=0, EMPTY=1, ALMOST_FULL=0, ALMOST_EMPTY=1, ERROR=0, COUNT=0. Pointers=0, thresholds=0, STATE=RESET. Memory contents are don't-care.
- Reset mid-operation discards all stored data.
- FSM states: RESET(0), INIT(1), IDLE(2), ACTIVE(3), ERROR(4).
  - RESET -> INIT on first edge with RESET_L=1.
  - INIT: latch TH_FULL/TH_EMPTY; no push/pop accepted; -> IDLE next cycle.
  - IDLE (COUNT==0) <-> ACTIVE (COUNT>0), following the next-cycle COUNT.
  - IDLE/ACTIVE -> ERROR on any overflow or underflow.
- ENB=0: no accepts, no state change, outputs hold; VALID_OUT forced 0.
- Push accepted when ENB && sWrite && state in {IDLE, ACTIVE} && (!FULL || pop accepted same cycle).
  - mem[wr_ptr] <= inputData; wr_ptr increments modulo BUFFER_DEPTH, natural wrap.
- Pop accepted when ENB && sRead && state in {IDLE, ACTIVE} && !EMPTY.
  - outputData <= mem[rd_ptr] and VALID_OUT=1 on the following edge (1-cycle latency); rd_ptr wraps modulo depth.
- Simultaneous push+pop:
  - not empty: both accepted, COUNT unchanged, works at FULL.
  - EMPTY: only push accepted; pop is an underflow.
- Overflow: sWrite while FULL without an accepted pop. Data dropped, ERROR=1, -> ERROR.
- Underflow: sRead while EMPTY. outputData holds, VALID_OUT=0, ERROR=1, -> ERROR.
- ERROR state: no push/pop accepted; pointers/COUNT frozen; ERROR held at 1 until reset.
- COUNT and all flags are registered, updated on the same edge as the pointers, so they are always mutually consistent.
- Thresholds outside 0..BUFFER_DEPTH behave per the unsigned compare; no saturation.

Optional Feature:
- Macro FIFO_ERR_RECOVER_EN.
- Defined: ERROR state lasts exactly one cycle (ERROR output pulses 1 cycle), then -> IDLE or ACTIVE per COUNT. Stored data is preserved and the offending request is dropped.
- Undefined: ERROR is sticky until RESET_L=0.

Decomposition:
- Shared package/include: FSM state encodings (RESET..ERROR, 3-bit), and the BUFFER_DEPTH==2**ADDRESS_WIDTH check as an elaboration-time assertion.
- One sub-module: memory_dp.
  - Ports: CLK, write enable, write address, write data, read address, registered read data.
  - DATA_WIDTH x BUFFER_DEPTH, no reset on the array.
- fifo_ctrl_thr holds the FSM, pointers, COUNT and flags.

Test Plan (DATA_WIDTH=8, ADDRESS_WIDTH=3, TH_FULL=6, TH_EMPTY=1):
- Reset, then release -> STATE goes RESET->INIT->IDLE; EMPTY=1, ALMOST_EMPTY=1, COUNT=0.
- Push 1,2,4,8,16,32 -> COUNT=6, ALMOST_FULL=1 after 6th; push 64,128 -> FULL=1, COUNT=8.
- From full, push+pop same cycle with data 0xAA -> outputData=1 next cycle, VALID_OUT=1, COUNT stays 8, no ERROR.
- Pop all 8 -> outputs 2,4,8,16,32,64,128,0xAA in order (across pointer wrap); EMPTY=1 at end.
- Push while FULL (no pop) -> ERROR=1, STATE=4, COUNT stays 8. Without macro, ERROR holds until reset; with FIFO_ERR_RECOVER_EN, 1-cycle pulse, then ACTIVE.
- Pop while EMPTY; separately hold ENB=0 with sWrite=1 for 3 cycles -> underflow sets ERROR; ENB=0 case leaves COUNT and pointers unchanged.
